// File: rtl/inst_fetch.sv
// ============================================================================
// Module   : inst_fetch
// Purpose  : RISC-V IF stage; assembles 32-bit instructions from four
//            little-endian byte reads and presents them to IF/ID.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch #(
  parameter int unsigned            ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              stall,
  input  logic              br_flag,
  input  logic [ADDR_W-1:0] br_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_inst,
  output logic              if_valid
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_pc;
  logic [23:0]       r_buf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= FETCH;
      r_cnt    <= 2'd0;
      r_pc     <= RESET_PC;
      r_buf    <= 24'd0;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      if_pc    <= '0;
      if_inst  <= 32'd0;
      if_valid <= 1'b0;
    end else if (rdy) begin
      if (br_flag) begin
        // Redirect wins over any ack or held instruction this cycle
        r_pc     <= br_target;
        r_cnt    <= 2'd0;
        if_valid <= 1'b0;
        r_state  <= FETCH;
        mem_req  <= 1'b1;
        mem_addr <= br_target;
      end else begin
        case (r_state)
          FETCH: begin
            mem_req <= 1'b1;
            if (mem_req && mem_ack) begin
              if (r_cnt != 2'd3) begin
                case (r_cnt)
                  2'd0:    r_buf[7:0]   <= mem_rdata;
                  2'd1:    r_buf[15:8]  <= mem_rdata;
                  default: r_buf[23:16] <= mem_rdata;
                endcase
                r_cnt    <= r_cnt + 2'd1;
                mem_addr <= r_pc + ADDR_W'(r_cnt) + ADDR_W'(1);
              end else begin
                if_inst  <= {mem_rdata, r_buf};
                if_pc    <= r_pc;
                if_valid <= 1'b1;
                r_pc     <= r_pc + ADDR_W'(4);
                r_cnt    <= 2'd0;
                mem_req  <= 1'b0;
                mem_addr <= r_pc + ADDR_W'(4);
                r_state  <= HOLD;
              end
            end
          end
          HOLD: begin
            mem_req <= 1'b0;
            if (!stall) begin
              if_valid <= 1'b0;
              mem_req  <= 1'b1;
              r_state  <= FETCH;
            end
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Scoreboard bench for inst_fetch with a byte-wide memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        stall;
  logic        br_flag;
  logic [31:0] br_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  always #5 clk = ~clk;

  inst_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .stall     (stall),
    .br_flag   (br_flag),
    .br_target (br_target),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .if_valid  (if_valid)
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 8'h13;
      32'h0000_0001: return 8'h05;
      32'h0000_0002: return 8'h10;
      32'h0000_0003: return 8'h00;
      32'h0000_0004: return 8'h93;
      32'h0000_0005: return 8'h05;
      32'h0000_0006: return 8'h20;
      32'h0000_0007: return 8'h00;
      32'h0000_1000: return 8'h33;
      32'h0000_1001: return 8'h06;
      32'h0000_1002: return 8'hB5;
      32'h0000_1003: return 8'h00;
      32'h0000_1004: return 8'h93;
      32'h0000_1005: return 8'h86;
      32'h0000_1006: return 8'h05;
      32'h0000_1007: return 8'h00;
      32'hFFFF_FFFE: return 8'h6F;
      32'hFFFF_FFFF: return 8'hFF;
      default:       return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Zero-wait memory: data returns in the same cycle the request is seen
  assign mem_ack   = mem_req & rdy;
  assign mem_rdata = mem_byte(mem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_inst(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    e.pc   = pc;
    e.inst = inst;
    sb.push_back(e);
  endtask

  task automatic wait_addr(input logic [31:0] a);
    int k;
    k = 0;
    @(negedge clk);
    while (!(mem_req && mem_addr == a) && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (!(mem_req && mem_addr == a)) begin
      n_fail++;
      $display("FAIL wait_addr: got addr %h req %b expected addr %h req 1", mem_addr, mem_req, a);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_valid && n < 40);
    n_checks++;
    if (!if_valid) begin
      n_fail++;
      $display("FAIL wait_valid: got if_valid %b expected 1 within 40 cycles", if_valid);
    end
  endtask

  // Monitor: every new presentation must match the head of the scoreboard
  always @(negedge clk) begin
    if (if_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_inst: got pc %h inst %h expected none", if_pc, if_inst);
      end else begin
        mon_e = sb.pop_front();
        check("sb_if_pc", if_pc, mon_e.pc);
        check("sb_if_inst", if_inst, mon_e.inst);
      end
    end
    prev_valid <= if_valid;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst       = 1'b0;
    rdy       = 1'b1;
    stall     = 1'b0;
    br_flag   = 1'b0;
    br_target = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_inst", if_inst, 32'h0);

    // Basic fetch at pc 0
    expect_inst(32'h0, 32'h0010_0513);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_mem_req", mem_req, 1);
      check("t1_mem_addr", mem_addr, 32'(i));
    end
    @(negedge clk);
    check("t1_if_valid", if_valid, 1);
    check("t1_req_low", mem_req, 0);
    check("t1_next_addr", mem_addr, 32'h4);

    // Stall holds the instruction
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_hold_valid", if_valid, 1);
      check("t2_hold_req", mem_req, 0);
      check("t2_hold_pc", if_pc, 32'h0);
      check("t2_hold_inst", if_inst, 32'h0010_0513);
    end
    stall = 1'b0;
    @(negedge clk);
    check("t2_bubble_valid", if_valid, 0);
    check("t2_refetch_req", mem_req, 1);
    check("t2_refetch_addr", mem_addr, 32'h4);
    expect_inst(32'h4, 32'h0020_0593);
    wait_valid(n);
    check("t2_latency", 32'(n), 32'd4);

    // Redirect during byte 2 of the fetch at pc 8
    wait_addr(32'h0000_000A);
    br_flag   = 1'b1;
    br_target = 32'h0000_1000;
    expect_inst(32'h1000, 32'h00B5_0633);
    @(negedge clk);
    br_flag = 1'b0;
    check("t3_br_addr", mem_addr, 32'h1000);
    check("t3_br_req", mem_req, 1);
    check("t3_br_valid", if_valid, 0);
    wait_valid(n);
    check("t3_latency", 32'(n), 32'd4);

    // rdy pause mid-fetch (cnt 2)
    expect_inst(32'h1004, 32'h0005_8693);
    wait_addr(32'h0000_1006);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_frozen_addr", mem_addr, 32'h1006);
      check("t4_frozen_req", mem_req, 1);
      check("t4_frozen_valid", if_valid, 0);
    end
    rdy = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_valid && n < 20);
    check("t4_resume_latency", 32'(n), 32'd2);

    // Asynchronous reset during byte 3 of the fetch at pc 1008
    wait_addr(32'h0000_100B);
    #2 rst = 1'b0;
    #1;
    check("t5_async_valid", if_valid, 0);
    check("t5_async_req", mem_req, 0);
    check("t5_async_addr", mem_addr, 32'h0);
    check("t5_async_pc", if_pc, 32'h0);
    check("t5_async_inst", if_inst, 32'h0);
    expect_inst(32'h0, 32'h0010_0513);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_restart_req", mem_req, 1);
    check("t5_restart_addr", mem_addr, 32'h0);
    wait_valid(n);

    // Redirect from HOLD under stall, into a wrapping address range
    stall     = 1'b1;
    br_flag   = 1'b1;
    br_target = 32'hFFFF_FFFE;
    expect_inst(32'hFFFF_FFFE, 32'h0513_FF6F);
    @(negedge clk);
    br_flag = 1'b0;
    stall   = 1'b0;
    check("t6_drop_valid", if_valid, 0);
    check("t6_addr0", mem_addr, 32'hFFFF_FFFE);
    @(negedge clk);
    check("t6_addr1", mem_addr, 32'hFFFF_FFFF);
    @(negedge clk);
    check("t6_addr2", mem_addr, 32'h0000_0000);
    @(negedge clk);
    check("t6_addr3", mem_addr, 32'h0000_0001);
    @(negedge clk);
    check("t6_wrap_valid", if_valid, 1);
    check("t6_next_pc", mem_addr, 32'h0000_0002);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
